// File: rtl/fft_input_loader.sv
// fft_input_loader
//   Front end for a decimation-in-time FFT. Samples arriving over a
//   valid/ready stream are written into the working bank at bit-reversed
//   addresses (reversed over log2(N) bits), so the butterfly core sees the
//   scrambled input order it needs. After the last write of a frame a
//   one-cycle fft_start pulse is sent and input is held off until the core
//   signals fft_done.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
//   in_ready are both high. in_ready depends only on state (high in LOAD),
//   so it never combinationally depends on in_valid. in_last is meaningful
//   only when in_valid is high.
//
// Ports
//   clk, reset    clock (rising edge), asynchronous active-high reset
//   start_load    request to begin a frame (acted on only in IDLE)
//   N_config      transform size, sampled when start_load is accepted
//   in_valid/in_ready/in_data/in_last   input sample stream, {re, im}
//   mem_we/mem_addr/mem_wdata           bank write port, one cycle after transfer
//   fft_start     one-cycle pulse to the core after the final write
//   fft_done      completion pulse from the core
//   busy          high whenever the block is not IDLE
//   sample_cnt    samples accepted in the current frame
//   cfg_err       sticky: illegal N_config seen on start_load
//   len_err       sticky: in_last arrived before the final sample
//   state_dbg     current FSM state (0 IDLE, 1 LOAD, 2 START, 3 WAIT_FFT)

module fft_input_loader #(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N),
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_load,
  input  logic [ADDR_WIDTH:0]     N_config,
  input  logic                    in_valid,
  input  logic [2*DATA_WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [2*DATA_WIDTH-1:0] mem_wdata,
  output logic                    fft_start,
  input  logic                    fft_done,
  output logic                    busy,
  output logic [ADDR_WIDTH:0]     sample_cnt,
  output logic                    cfg_err,
  output logic                    len_err,
  output logic [1:0]              state_dbg
);

  localparam int LGW = $clog2(ADDR_WIDTH + 1);
  localparam logic [ADDR_WIDTH:0] ONE_N = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] TWO_N = (ADDR_WIDTH + 1)'(2);
  localparam logic [ADDR_WIDTH:0] MAX_C = (ADDR_WIDTH + 1)'(MAX_N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH:0]   n_q;       // latched frame size
  logic [LGW-1:0]        shamt_q;   // ADDR_WIDTH - log2(N)
  logic                  cfg_ok;
  logic [LGW-1:0]        cfg_lg;
  logic                  xfer;
  logic                  is_last;
  logic [ADDR_WIDTH-1:0] full_rev;
  logic [ADDR_WIDTH-1:0] wr_addr;

  // Legal sizes: power of two in [2, MAX_N]
  always_comb begin
    cfg_ok = (N_config != '0) && ((N_config & (N_config - ONE_N)) == '0) &&
             (N_config >= TWO_N) && (N_config <= MAX_C);
  end

  // log2 of N_config as the index of its highest set bit
  always_comb begin
    cfg_lg = '0;
    for (int k = 0; k <= ADDR_WIDTH; k++) begin
      if (N_config[k]) cfg_lg = LGW'(k);
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;
  assign xfer      = in_valid && in_ready;
  assign is_last   = (sample_cnt == (n_q - ONE_N));

  // Reversing all ADDR_WIDTH bits and shifting right by ADDR_WIDTH-lg is
  // the same as reversing only the low lg bits, because the index is < N.
  always_comb begin
    full_rev = '0;
    for (int j = 0; j < ADDR_WIDTH; j++) begin
      full_rev[j] = sample_cnt[ADDR_WIDTH-1-j];
    end
    wr_addr = full_rev >> shamt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_load && cfg_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (xfer) begin
          if (is_last)      state_d = S_START;
          else if (in_last) state_d = S_IDLE;   // short frame: abort
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (fft_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q        <= '0;
      shamt_q    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fft_start  <= 1'b0;
      sample_cnt <= '0;
      cfg_err    <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      mem_we <= xfer;
      // START is the cycle of the final write; the pulse follows it so the
      // core never sees fft_start alongside a write.
      fft_start <= (state_q == S_START);

      if (xfer) begin
        mem_addr   <= wr_addr;
        mem_wdata  <= in_data;
        sample_cnt <= sample_cnt + ONE_N;
        if (in_last && !is_last) len_err <= 1'b1;
      end

      if ((state_q == S_IDLE) && start_load) begin
        if (cfg_ok) begin
          n_q        <= N_config;
          shamt_q    <= LGW'(ADDR_WIDTH) - cfg_lg;
          sample_cnt <= '0;
          cfg_err    <= 1'b0;
          len_err    <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader (MAX_N = 32).
module tb_fft_input_loader;

  localparam int MAX_N = 32;
  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int EW    = AW + 2*DW;

  localparam int HAND8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  localparam int HAND5 [5] = '{0, 4, 2, 6, 1};
  localparam int HAND4 [4] = '{0, 2, 1, 3};

  logic          clk = 1'b0;
  logic          reset;
  logic          start_load;
  logic [AW:0]   N_config;
  logic          in_valid;
  logic [2*DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [2*DW-1:0] mem_wdata;
  logic          fft_start;
  logic          fft_done;
  logic          busy;
  logic [AW:0]   sample_cnt;
  logic          cfg_err;
  logic          len_err;
  logic [1:0]    state_dbg;

  fft_input_loader #(.MAX_N(MAX_N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start_load(start_load), .N_config(N_config),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fft_start(fft_start), .fft_done(fft_done), .busy(busy),
    .sample_cnt(sample_cnt), .cfg_err(cfg_err), .len_err(len_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int start_cnt = 0;
  int start_cyc = -1;
  int last_we_cyc = -1;
  int overlap  = 0;
  int we_err   = 0;
  bit chk_we_en = 1'b0;
  bit pend     = 1'b0;

  always @(posedge clk) cyc++;

  // Observe outputs mid-cycle. A write must follow exactly the cycles in
  // which a transfer was set up.
  always @(negedge clk) begin
    if (mem_we) begin
      got_q.push_back({mem_addr, mem_wdata});
      last_we_cyc = cyc;
    end
    if (fft_start) begin
      start_cnt++;
      start_cyc = cyc;
      if (mem_we) overlap++;
    end
    if (chk_we_en && (mem_we !== pend)) we_err++;
    pend = in_valid && in_ready;
  end

  function automatic int bit_rev(input int v, input int lg);
    int r = 0;
    for (int b = 0; b < lg; b++) r = (r << 1) | ((v >> b) & 1);
    return r;
  endfunction

  function automatic logic [2*DW-1:0] fdata(input int tag, input int i);
    return {16'(tag * 256 + i), 16'(40000 - i)};
  endfunction

  // ---------------- driver tasks (enter/exit 1 time unit after posedge) ----------------
  task automatic do_start(input int n);
    start_load = 1'b1;
    N_config   = (AW + 1)'(n);
    @(posedge clk); #1;
    start_load = 1'b0;
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offers samples until n_send have transferred; pushes expected writes.
  task automatic send_frame(input int n_send, input int last_idx, input bit rnd,
                            input int lg, input int tag);
    int i = 0;
    int guard = 0;
    logic rdy;
    while (i < n_send && guard < 2000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = fdata(tag, i);
      in_last  = (i == last_idx);
      rdy = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        exp_q.push_back({AW'(bit_rev(i, lg)), fdata(tag, i)});
        i++;
      end
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_cnt++;
    if (i !== n_send) $display("FAIL send_frame_timeout: transferred %0d required %0d", i, n_send);
    else pass_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    chk_cnt++;
    if ({in_ready, mem_we, fft_start, busy, cfg_err, len_err} !== 6'b0)
      $display("FAIL reset_flags: got %b required 000000", {in_ready, mem_we, fft_start, busy, cfg_err, len_err});
    else pass_cnt++;
    chk_cnt++;
    if ({mem_addr, mem_wdata, sample_cnt} !== '0)
      $display("FAIL reset_values: addr %0d data %h cnt %0d required 0", mem_addr, mem_wdata, sample_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d required 0", state_dbg);
    else pass_cnt++;

    // Abort a frame with reset after three samples
    do_start(8);
    send_frame(3, -1, 1'b0, 3, 1);
    chk_cnt++;
    if (sample_cnt !== 6'd3) $display("FAIL reset_pre_cnt: got %0d required 3", sample_cnt);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if ({in_ready, busy} !== 2'b00) $display("FAIL reset_async: in_ready/busy %b required 00", {in_ready, busy});
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
    step(1);
    chk_cnt++;
    if ({busy, sample_cnt, state_dbg} !== '0)
      $display("FAIL reset_release: busy %b cnt %0d state %0d required 0", busy, sample_cnt, state_dbg);
    else pass_cnt++;
  endtask

  task automatic test_n8();
    int gbase, sbase, bad;
    logic [EW-1:0] e;
    exp_q.delete();
    gbase = got_q.size();
    sbase = start_cnt;
    do_start(8);
    send_frame(8, 7, 1'b0, 3, 2);
    step(3);
    chk_cnt++;
    if (got_q.size() - gbase !== 8) $display("FAIL n8_write_count: got %0d required 8", got_q.size() - gbase);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (gbase + k >= got_q.size()) bad++;
      else begin
        e = got_q[gbase + k];
        if (int'(e[EW-1:2*DW]) != HAND8[k] || e[2*DW-1:0] !== fdata(2, k)) bad++;
      end
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL n8_addr_data: %0d bad writes required 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if (start_cnt - sbase !== 1) $display("FAIL n8_start_count: got %0d required 1", start_cnt - sbase);
    else pass_cnt++;
    chk_cnt++;
    if (start_cyc !== last_we_cyc + 1) $display("FAIL n8_start_timing: start cycle %0d required %0d", start_cyc, last_we_cyc + 1);
    else pass_cnt++;
    chk_cnt++;
    if (overlap !== 0) $display("FAIL n8_overlap: got %0d required 0", overlap);
    else pass_cnt++;
    chk_cnt++;
    if ({busy, in_ready, sample_cnt} !== {1'b1, 1'b0, 6'd8})
      $display("FAIL n8_wait: busy %b ready %b cnt %0d required 1 0 8", busy, in_ready, sample_cnt);
    else pass_cnt++;
    pulse_done();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL n8_done: busy %b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_n32_random();
    int gbase, bad;
    logic [EW-1:0] e;
    exp_q.delete();
    gbase = got_q.size();
    we_err = 0;
    chk_we_en = 1'b1;
    do_start(32);
    send_frame(32, 31, 1'b1, 5, 3);
    step(3);
    chk_we_en = 1'b0;
    chk_cnt++;
    if (got_q.size() - gbase !== 32) $display("FAIL n32_write_count: got %0d required 32", got_q.size() - gbase);
    else pass_cnt++;
    chk_cnt++;
    if (we_err !== 0) $display("FAIL n32_write_timing: %0d stray/missing writes required 0", we_err);
    else pass_cnt++;
    e = (got_q.size() > gbase + 6) ? got_q[gbase + 1] : '0;
    chk_cnt++;
    if (e[EW-1:2*DW] !== 5'd16) $display("FAIL n32_idx1_addr: got %0d required 16", e[EW-1:2*DW]);
    else pass_cnt++;
    e = (got_q.size() > gbase + 6) ? got_q[gbase + 6] : '0;
    chk_cnt++;
    if (e[EW-1:2*DW] !== 5'd12) $display("FAIL n32_idx6_addr: got %0d required 12", e[EW-1:2*DW]);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < exp_q.size(); k++)
      if (gbase + k >= got_q.size() || got_q[gbase + k] !== exp_q[k]) bad++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL n32_scoreboard: %0d bad writes required 0", bad);
    else pass_cnt++;
    pulse_done();
  endtask

  task automatic test_len_err();
    int gbase, sbase, bad;
    logic [EW-1:0] e;
    exp_q.delete();
    gbase = got_q.size();
    sbase = start_cnt;
    do_start(8);
    send_frame(5, 4, 1'b0, 3, 4);
    step(3);
    chk_cnt++;
    if (got_q.size() - gbase !== 5) $display("FAIL len_write_count: got %0d required 5", got_q.size() - gbase);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (gbase + k >= got_q.size()) bad++;
      else begin
        e = got_q[gbase + k];
        if (int'(e[EW-1:2*DW]) != HAND5[k] || e[2*DW-1:0] !== fdata(4, k)) bad++;
      end
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL len_addr_data: %0d bad writes required 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if ({len_err, busy} !== 2'b10) $display("FAIL len_flag: len_err/busy %b required 10", {len_err, busy});
    else pass_cnt++;
    chk_cnt++;
    if (start_cnt - sbase !== 0) $display("FAIL len_no_start: got %0d pulses required 0", start_cnt - sbase);
    else pass_cnt++;
    chk_cnt++;
    if (sample_cnt !== 6'd5) $display("FAIL len_cnt: got %0d required 5", sample_cnt);
    else pass_cnt++;
    do_start(8);
    chk_cnt++;
    if ({len_err, busy, sample_cnt} !== {1'b0, 1'b1, 6'd0})
      $display("FAIL len_clear: len_err %b busy %b cnt %0d required 0 1 0", len_err, busy, sample_cnt);
    else pass_cnt++;
    send_frame(8, 7, 1'b0, 3, 5);
    step(2);
    pulse_done();
  endtask

  task automatic test_cfg_err();
    int gbase, bad;
    logic [EW-1:0] e;
    // 64 does not fit the 6-bit port and arrives as 0
    int bad_n [3] = '{12, 64, 1};
    for (int v = 0; v < 3; v++) begin
      do_start(bad_n[v]);
      step(1);
      chk_cnt++;
      if ({cfg_err, busy} !== 2'b10) $display("FAIL cfg_illegal_%0d: cfg_err/busy %b required 10", bad_n[v], {cfg_err, busy});
      else pass_cnt++;
    end
    exp_q.delete();
    gbase = got_q.size();
    do_start(4);
    chk_cnt++;
    if ({cfg_err, busy} !== 2'b01) $display("FAIL cfg_clear: cfg_err/busy %b required 01", {cfg_err, busy});
    else pass_cnt++;
    send_frame(4, 3, 1'b0, 2, 6);
    step(2);
    bad = (got_q.size() - gbase == 4) ? 0 : 1;
    for (int k = 0; k < 4; k++) begin
      if (gbase + k < got_q.size()) begin
        e = got_q[gbase + k];
        if (int'(e[EW-1:2*DW]) != HAND4[k] || e[2*DW-1:0] !== fdata(6, k)) bad++;
      end
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL cfg_n4_writes: %0d bad writes required 0", bad);
    else pass_cnt++;
    pulse_done();
  endtask

  task automatic test_wait_fft();
    int gbase, g1, bad;
    logic ready_seen;
    exp_q.delete();
    do_start(16);
    send_frame(16, 15, 1'b0, 4, 7);
    step(2);
    g1 = got_q.size();
    ready_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      start_load = 1'b1;
      N_config   = 6'd8;
      in_valid   = 1'b1;
      ready_seen = ready_seen | in_ready;
      step(1);
    end
    start_load = 1'b0;
    in_valid   = 1'b0;
    step(2);
    chk_cnt++;
    if (ready_seen !== 1'b0) $display("FAIL wait_ready: in_ready seen %b required 0", ready_seen);
    else pass_cnt++;
    chk_cnt++;
    if (got_q.size() !== g1) $display("FAIL wait_no_write: got %0d writes required 0", got_q.size() - g1);
    else pass_cnt++;
    chk_cnt++;
    if ({busy, state_dbg, sample_cnt} !== {1'b1, 2'd3, 6'd16})
      $display("FAIL wait_hold: busy %b state %0d cnt %0d required 1 3 16", busy, state_dbg, sample_cnt);
    else pass_cnt++;
    pulse_done();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL wait_done: busy %b required 0", busy);
    else pass_cnt++;

    // Second frame after the core finished
    exp_q.delete();
    gbase = got_q.size();
    do_start(16);
    send_frame(16, 15, 1'b1, 4, 8);
    step(3);
    bad = (got_q.size() - gbase == 16) ? 0 : 1;
    for (int k = 0; k < exp_q.size(); k++)
      if (gbase + k >= got_q.size() || got_q[gbase + k] !== exp_q[k]) bad++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL second_frame: %0d bad writes required 0", bad);
    else pass_cnt++;
    e_dummy();
    pulse_done();
  endtask

  task automatic e_dummy();
    // Final write of a 16-point frame lands at bit-reverse(15) = 15
    chk_cnt++;
    if (got_q.size() == 0 || got_q[got_q.size() - 1][EW-1:2*DW] !== 5'd15)
      $display("FAIL n16_last_addr: got %0d required 15", (got_q.size() == 0) ? 0 : int'(got_q[got_q.size() - 1][EW-1:2*DW]));
    else pass_cnt++;
  endtask

  initial begin
    reset      = 1'b1;
    start_load = 1'b0;
    N_config   = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    fft_done   = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);

    test_reset();
    test_n8();
    test_n32_random();
    test_len_err();
    test_cfg_err();
    test_wait_fft();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
